fft_reorder_buf: RTL and testbench

- Parametrised, streaming digit-reversal reorder buffer for the FFT datapath.
- Accepts one complex sample per cycle in natural order and emits each N-sample frame in bit-reversed (RADIX=2) or base-4 digit-reversed (RADIX=4) order.
- Sits at the input or output of the SDF FFT cores (e.g. `fft_top`), so stimulus and results no longer need manual reordering.
- Uses a ping-pong pair of frame banks with ready/valid backpressure on both sides.

---
 rtl/fft_pkg.sv | 38 +++
 rtl/fft_digit_rev.sv | 24 ++
 rtl/fft_reorder_buf.sv | 193 +++++++++++++++++++
 tb/tb_fft_reorder_buf.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT streaming blocks: size helpers, parameter
// legality check and the reorder buffer read-side state encoding.
package fft_pkg;

  // Ceiling log2 for elaboration-time sizing (returns 0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

  // Number of base-RADIX digits in an index into an N-entry frame.
  function automatic int digit_count(input int n, input int radix);
    return clog2(n) / clog2(radix);
  endfunction

  // True when N is an exact power of RADIX and RADIX is 2 or 4.
  function automatic bit params_legal(input int n, input int radix);
    bit ok;
    ok = (radix == 2) || (radix == 4);
    ok = ok && (n >= radix);
    ok = ok && ((1 << clog2(n)) == n);
    if (ok) begin
      ok = (clog2(n) % clog2(radix)) == 0;
    end
    return ok;
  endfunction

  // Read side: idle until a full bank is available, then stream it out.
  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/fft_digit_rev.sv
// Combinational index reverser: swaps the order of the base-RADIX digits of
// an index (bit reversal for RADIX=2, two-bit digit reversal for RADIX=4).
module fft_digit_rev
  import fft_pkg::*;
#(
  parameter int N     = 16,
  parameter int RADIX = 4
) (
  input  logic [clog2(N)-1:0] idx_i,
  output logic [clog2(N)-1:0] rev_o
);

  localparam int DW = clog2(RADIX);
  localparam int ND = digit_count(N, RADIX);

  // Digit d of the result is digit (ND-1-d) of the input.
  always_comb begin
    rev_o = '0;
    for (int d = 0; d < ND; d++) begin
      rev_o[d*DW +: DW] = idx_i[(ND-1-d)*DW +: DW];
    end
  end

endmodule

// File: rtl/fft_reorder_buf.sv
// Streaming digit-reversal reorder buffer. Samples are written in natural
// order into one of two frame banks; a full bank is read back in
// digit-reversed order through a two-register pipeline (RAM output register,
// then output register).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (input_en/input_ready upstream, output_en/output_ready
// downstream). Ready may depend combinationally only on internal state; while
// output_en is high and output_ready is low the output payload is held.
//
// A bank is released as soon as its last element has been read out of the
// RAM into the pipeline: its contents are no longer needed, and releasing it
// there lets continuous input and output run without input_ready dropping.
module fft_reorder_buf
  import fft_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 16,
  parameter int RADIX = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             input_en,
  output logic             input_ready,
  input  logic [WIDTH-1:0] input_real,
  input  logic [WIDTH-1:0] input_imag,
  output logic             output_en,
  input  logic             output_ready,
  output logic [WIDTH-1:0] output_real,
  output logic [WIDTH-1:0] output_imag,
  output logic             output_last,
  output logic             debug_rd_state
);

  localparam int AW = clog2(N);
  localparam int DW = 2 * WIDTH;

  if (!params_legal(N, RADIX)) begin : g_bad_params
    $error("fft_reorder_buf: N must be a power of RADIX, RADIX must be 2 or 4");
  end

  // Write side
  logic [AW-1:0] wcount_q, wcount_d;
  logic          wbank_q, wbank_d;
  // Read (RAM issue) side
  logic [AW-1:0] rcount_q, rcount_d;
  logic          rbank_q, rbank_d;
  logic [1:0]    full_q, full_d;
  rd_state_e     state_q, state_d;

  // Pipeline
  logic             s1_valid_q, s1_last_q;
  logic [DW-1:0]    rd_data_q;
  logic             out_valid_q, out_last_q;
  logic [WIDTH-1:0] out_re_q, out_im_q;

  logic [DW-1:0] mem_q [2*N];

  logic          wr_fire, wr_done;
  logic          out_load, s1_free;
  logic          issue_go, issue_fire, rd_last;
  logic [AW-1:0] raddr_rev;

  assign input_ready = !full_q[wbank_q];
  assign wr_fire     = input_en && input_ready;
  assign wr_done     = wr_fire && (wcount_q == AW'(N - 1));

  // The output register can take new data when empty or being accepted;
  // stage 1 can take new data when empty or moving into the output register.
  assign out_load = !out_valid_q || output_ready;
  assign s1_free  = !s1_valid_q || out_load;
  assign rd_last  = (rcount_q == AW'(N - 1));

  fft_digit_rev #(
    .N     (N),
    .RADIX (RADIX)
  ) u_rev (
    .idx_i (rcount_q),
    .rev_o (raddr_rev)
  );

  // Read-side FSM: decide whether a RAM read is issued this cycle and where
  // the FSM goes next. IDLE issues immediately when a bank is full so the
  // first output appears two edges after the frame completes.
  always_comb begin
    state_d  = state_q;
    issue_go = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (full_q[rbank_q]) begin
          issue_go = 1'b1;
          state_d  = RD_STREAM;
        end
      end
      RD_STREAM: begin
        issue_go = 1'b1;
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase
    issue_fire = issue_go && s1_free;
    if ((state_q == RD_STREAM) && issue_fire && rd_last) begin
      state_d = full_q[~rbank_q] ? RD_STREAM : RD_IDLE;
    end
  end

  // Counter and bank bookkeeping: write completion marks a bank full, the
  // final read of a bank releases it. They always touch different banks.
  always_comb begin
    wcount_d = wcount_q;
    wbank_d  = wbank_q;
    rcount_d = rcount_q;
    rbank_d  = rbank_q;
    full_d   = full_q;
    if (wr_fire) begin
      wcount_d = wcount_q + AW'(1);
      if (wr_done) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end
    if (issue_fire) begin
      rcount_d = rcount_q + AW'(1);
      if (rd_last) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RD_IDLE;
      wcount_q <= '0;
      wbank_q  <= 1'b0;
      rcount_q <= '0;
      rbank_q  <= 1'b0;
      full_q   <= '0;
    end else begin
      state_q  <= state_d;
      wcount_q <= wcount_d;
      wbank_q  <= wbank_d;
      rcount_q <= rcount_d;
      rbank_q  <= rbank_d;
      full_q   <= full_d;
    end
  end

  // Frame storage: both banks in one RAM, bank select as address MSB, with a
  // registered read port enabled only when a read is issued.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem_q[{wbank_q, wcount_q}] <= {input_real, input_imag};
    end
    if (issue_fire) begin
      rd_data_q <= mem_q[{rbank_q, raddr_rev}];
    end
  end

  // Valid/last tracking for the RAM register and the output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      if (s1_free) begin
        s1_valid_q <= issue_fire;
        s1_last_q  <= issue_fire && rd_last;
      end
      if (out_load) begin
        out_valid_q <= s1_valid_q;
        out_last_q  <= s1_last_q;
        if (s1_valid_q) begin
          out_re_q <= rd_data_q[DW-1:WIDTH];
          out_im_q <= rd_data_q[WIDTH-1:0];
        end
      end
    end
  end

  assign output_en      = out_valid_q;
  assign output_last    = out_last_q;
  assign output_real    = out_re_q;
  assign output_imag    = out_im_q;
  assign debug_rd_state = (state_q == RD_STREAM);

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Directed bench for fft_reorder_buf. Three instances share the control
// inputs: RADIX=4/WIDTH=32, RADIX=2/WIDTH=32 and RADIX=4/WIDTH=16. Expected
// output orders are hand-written tables.
module tb_fft_reorder_buf;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT wiring ----------------
  logic        input_en     = 1'b0;
  logic        output_ready = 1'b0;
  logic [31:0] in_re32 = '0, in_im32 = '0;
  logic [15:0] in_re16 = '0, in_im16 = '0;

  logic        r4_in_ready, r4_en, r4_last, r4_dbg;
  logic [31:0] r4_re, r4_im;
  logic        r2_in_ready, r2_en, r2_last, r2_dbg;
  logic [31:0] r2_re, r2_im;
  logic        x16_in_ready, x16_en, x16_last, x16_dbg;
  logic [15:0] x16_re, x16_im;

  fft_reorder_buf #(.WIDTH(32), .N(16), .RADIX(4)) u_r4 (
    .clock(clock), .reset(reset), .input_en(input_en), .input_ready(r4_in_ready),
    .input_real(in_re32), .input_imag(in_im32), .output_en(r4_en),
    .output_ready(output_ready), .output_real(r4_re), .output_imag(r4_im),
    .output_last(r4_last), .debug_rd_state(r4_dbg)
  );

  fft_reorder_buf #(.WIDTH(32), .N(16), .RADIX(2)) u_r2 (
    .clock(clock), .reset(reset), .input_en(input_en), .input_ready(r2_in_ready),
    .input_real(in_re32), .input_imag(in_im32), .output_en(r2_en),
    .output_ready(output_ready), .output_real(r2_re), .output_imag(r2_im),
    .output_last(r2_last), .debug_rd_state(r2_dbg)
  );

  fft_reorder_buf #(.WIDTH(16), .N(16), .RADIX(4)) u_x16 (
    .clock(clock), .reset(reset), .input_en(input_en), .input_ready(x16_in_ready),
    .input_real(in_re16), .input_imag(in_im16), .output_en(x16_en),
    .output_ready(output_ready), .output_real(x16_re), .output_imag(x16_im),
    .output_last(x16_last), .debug_rd_state(x16_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] q4[$];
  logic [63:0] q2[$];
  logic [31:0] q16[$];

  int r4_cnt = 0, r2_cnt = 0, x16_cnt = 0;
  int acc_cyc_q[$];
  int last_cyc_q[$];
  int stall_cnt = 0;
  int last_acc_cyc = 0;

  int r4_ord [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
  int r2_ord [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // RADIX=4, WIDTH=32 output monitor
  always @(negedge clock) begin
    if (!reset && r4_en && output_ready) begin
      if (q4.size() == 0) check("r4_qempty", q4.size(), 1);
      else check("r4_data", {r4_re, r4_im}, q4.pop_front());
      check("r4_last", r4_last, (r4_cnt % 16) == 15);
      r4_cnt++;
      acc_cyc_q.push_back(cyc);
      if (r4_last) last_cyc_q.push_back(cyc);
    end
  end

  // RADIX=2, WIDTH=32 output monitor
  always @(negedge clock) begin
    if (!reset && r2_en && output_ready) begin
      if (q2.size() == 0) check("r2_qempty", q2.size(), 1);
      else check("r2_data", {r2_re, r2_im}, q2.pop_front());
      check("r2_last", r2_last, (r2_cnt % 16) == 15);
      r2_cnt++;
    end
  end

  // RADIX=4, WIDTH=16 output monitor
  always @(negedge clock) begin
    if (!reset && x16_en && output_ready) begin
      if (q16.size() == 0) check("x16_qempty", q16.size(), 1);
      else check("x16_data", {32'd0, x16_re, x16_im}, {32'd0, q16.pop_front()});
      check("x16_last", x16_last, (x16_cnt % 16) == 15);
      x16_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  // kind 0: real = base+k, imag = -(base+k); kind 1: full-scale extremes.
  function automatic logic [95:0] gen(input int kind, input int base, input int k);
    logic [31:0] re32, im32;
    logic [15:0] re16, im16;
    if (kind == 0) begin
      re32 = 32'(base + k);
      im32 = 32'(-(base + k));
      re16 = re32[15:0];
      im16 = im32[15:0];
    end else begin
      re32 = k[0] ? 32'h7fff_ffff : 32'h8000_0000;
      im32 = k[2] ? 32'h8000_0000 : 32'h7fff_ffff;
      re16 = k[0] ? 16'h7fff : 16'h8000;
      im16 = k[2] ? 16'h8000 : 16'h7fff;
    end
    return {re32, im32, re16, im16};
  endfunction

  task automatic send_sample(input logic [95:0] v);
    int n;
    input_en = 1'b1;
    in_re32  = v[95:64];
    in_im32  = v[63:32];
    in_re16  = v[31:16];
    in_im16  = v[15:0];
    n = 0;
    @(negedge clock);
    while (!r4_in_ready && n < 300) begin
      n++;
      stall_cnt++;
      @(negedge clock);
    end
    if (n >= 300) check("in_timeout", n, 0);
    @(posedge clock);
    #1;
    last_acc_cyc = cyc;
  endtask

  task automatic run_frame(input int kind, input int base);
    logic [95:0] v;
    for (int i = 0; i < 16; i++) begin
      v = gen(kind, base, r4_ord[i]);
      q4.push_back(v[95:32]);
      q16.push_back(v[31:0]);
      v = gen(kind, base, r2_ord[i]);
      q2.push_back(v[95:32]);
    end
    for (int k = 0; k < 16; k++) begin
      send_sample(gen(kind, base, k));
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(posedge clock);
      #1;
      if (q4.size() == 0 && q2.size() == 0 && q16.size() == 0) break;
    end
    check("drain", q4.size() + q2.size() + q16.size(), 0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int base_cnt;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_en", r4_en, 0);
    check("rst_last", r4_last, 0);
    check("rst_data", {r4_re, r4_im}, 64'd0);
    check("rst_ready", r4_in_ready, 1);
    check("rst_ready_r2", r2_in_ready, 1);
    check("rst_ready_x16", x16_in_ready, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    output_ready = 1'b1;

    // Tests 1/2: one frame, RADIX=4 and RADIX=2 orders, first-output latency
    run_frame(0, 0);
    input_en = 1'b0;
    n = 0;
    @(negedge clock);
    while (!r4_en && n < 10) begin
      n++;
      @(negedge clock);
    end
    check("latency", cyc - last_acc_cyc, 2);
    wait_drain();

    // Test 3: three back-to-back frames with output_ready held high
    stall_cnt = 0;
    acc_cyc_q.delete();
    last_cyc_q.delete();
    run_frame(0, 100);
    run_frame(0, 200);
    run_frame(0, 300);
    input_en = 1'b0;
    wait_drain();
    check("b2b_stall", stall_cnt, 0);
    check("b2b_count", acc_cyc_q.size(), 48);
    if (acc_cyc_q.size() == 48) check("b2b_contig", acc_cyc_q[47] - acc_cyc_q[0], 47);
    check("b2b_lasts", last_cyc_q.size(), 3);
    if (last_cyc_q.size() == 3) begin
      check("b2b_gap1", last_cyc_q[1] - last_cyc_q[0], 16);
      check("b2b_gap2", last_cyc_q[2] - last_cyc_q[1], 16);
    end

    // Test 4: backpressure from the start of streaming
    output_ready = 1'b0;
    stall_cnt = 0;
    run_frame(0, 400);
    run_frame(0, 416);
    check("bp_nostall", stall_cnt, 0);
    input_en = 1'b1;
    in_re32  = 32'd999;
    in_im32  = 32'd999;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_ready_low", r4_in_ready, 0);
      check("bp_en", r4_en, 1);
      check("bp_hold", {r4_re, r4_im}, {32'd400, 32'hFFFF_FE70});
      check("bp_last", r4_last, 0);
    end
    input_en = 1'b0;
    @(posedge clock);
    #1;
    output_ready = 1'b1;
    base_cnt = r4_cnt;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      if (r4_cnt >= base_cnt + 16) break;
    end
    check("bp_accepts", r4_cnt - base_cnt, 16);
    @(negedge clock);
    check("bp_recover", r4_in_ready, 1);
    wait_drain();

    // Test 5: reset after a partial frame of 7 samples
    for (int k = 0; k < 7; k++) begin
      send_sample(gen(0, 500, k));
    end
    input_en = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_en", r4_en, 0);
    check("mid_rst_ready", r4_in_ready, 1);
    check("mid_rst_data", {r4_re, r4_im}, 64'd0);
    check("mid_rst_dbg", r4_dbg, 0);
    @(posedge clock);
    #1;
    run_frame(0, 600);
    input_en = 1'b0;
    wait_drain();

    // Test 6: full-scale extremes, bit-exact at reversed positions
    run_frame(1, 0);
    input_en = 1'b0;
    wait_drain();

    check("final_cnt_r4", r4_cnt, 16 * 8);
    check("final_cnt_r2", r2_cnt, 16 * 8);
    check("final_cnt_x16", x16_cnt, 16 * 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
